// File: rtl/note_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : note_seq
//  Purpose  : 16-step note sequencer driving a synth's trig/osc_count inputs.
//             Define NOTE_SEQ_MIN_GATE_EN to enforce a MIN_GATE-tick floor
//             on the gate of every non-rest step.
//  Revision : 1.0  initial release
// ============================================================================
module note_seq #(
   parameter int TICK_DIV = 256,
   parameter int MIN_GATE = 2048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [7:0]  wr_data,
   input  logic        play,
   input  logic [3:0]  last_step,
   input  logic [15:0] step_len,
   input  logic [15:0] gate_len,
   output logic        trig,
   output logic [11:0] osc_count,
   output logic [3:0]  step_idx,
   output logic        step_strobe,
   output logic        playing
);

   localparam int c_presc_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);
`ifdef NOTE_SEQ_MIN_GATE_EN
   localparam logic [31:0] c_gate_floor = 32'(MIN_GATE);
`else
   // A zero floor leaves gate_len untouched, so gate_len=0 means no trig.
   localparam logic [31:0] c_gate_floor = 32'(MIN_GATE) & 32'd0;
`endif

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   function automatic logic [11:0] osc_of(input logic [7:0] w);
      logic [11:0] base;
      case (w[3:0])
         4'd0:    base = 12'd611;
         4'd1:    base = 12'd576;
         4'd2:    base = 12'd544;
         4'd3:    base = 12'd513;
         4'd4:    base = 12'd484;
         4'd5:    base = 12'd457;
         4'd6:    base = 12'd431;
         4'd7:    base = 12'd407;
         4'd8:    base = 12'd384;
         4'd9:    base = 12'd363;
         4'd10:   base = 12'd342;
         default: base = 12'd323;
      endcase
      return base >> w[6:4];
   endfunction

   state_t                 state_q, state_d;
   logic [7:0]             pat_q [16];
   logic [7:0]             word_q, word_d;
   logic [c_presc_w-1:0]   presc_q, presc_d;
   logic [15:0]            tick_q, tick_d;
   logic [3:0]             idx_q, idx_d;
   logic                   trig_q, trig_d;
   logic [11:0]            osc_q, osc_d;
   logic                   strobe_q, strobe_d;
   logic                   playing_q, playing_d;

   logic [15:0] len_eff;
   logic [31:0] gate_eff;
   logic        step_end;
   logic [3:0]  next_idx;
   logic        do_start;
   logic [3:0]  start_idx;
   logic [7:0]  new_word;

   assign len_eff  = (step_len == 16'd0) ? 16'd1 : step_len;
   assign gate_eff = ({16'd0, gate_len} > c_gate_floor) ? {16'd0, gate_len} : c_gate_floor;
   assign step_end = (presc_q == c_presc_last) && (tick_q >= (len_eff - 16'd1));
   // ">=" also catches last_step lowered below the playing step.
   assign next_idx = (idx_q >= last_step) ? 4'd0 : idx_q + 4'd1;

   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      presc_d   = presc_q;
      tick_d    = tick_q;
      idx_d     = idx_q;
      trig_d    = trig_q;
      osc_d     = osc_q;
      strobe_d  = 1'b0;
      playing_d = playing_q;
      do_start  = 1'b0;
      start_idx = 4'd0;
      new_word  = 8'h80;

      case (state_q)
         IDLE: begin
            presc_d   = '0;
            tick_d    = 16'd0;
            trig_d    = 1'b0;
            idx_d     = 4'd0;
            playing_d = 1'b0;
            if (play) begin
               state_d  = PLAY;
               do_start = 1'b1;
            end
         end
         PLAY: begin
            if (!play) begin
               state_d   = IDLE;
               trig_d    = 1'b0;
               playing_d = 1'b0;
               idx_d     = 4'd0;
               presc_d   = '0;
               tick_d    = 16'd0;
            end else if (step_end) begin
               do_start  = 1'b1;
               start_idx = next_idx;
            end else begin
               if (presc_q == c_presc_last) begin
                  presc_d = '0;
                  tick_d  = tick_q + 16'd1;
               end else begin
                  presc_d = presc_q + c_presc_w'(1);
               end
               trig_d = !word_q[7] && ({16'd0, tick_d} < gate_eff);
            end
         end
         default: state_d = IDLE;
      endcase

      // Step start: latch the word so later writes only affect the next visit.
      if (do_start) begin
         new_word  = pat_q[start_idx];
         idx_d     = start_idx;
         word_d    = new_word;
         presc_d   = '0;
         tick_d    = 16'd0;
         strobe_d  = 1'b1;
         playing_d = 1'b1;
         trig_d    = !new_word[7] && (gate_eff != 32'd0);
         if (!new_word[7]) begin
            osc_d = osc_of(new_word);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            pat_q[i] <= 8'h80;
         end
      end else if (wr_en) begin
         pat_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         word_q    <= 8'h80;
         presc_q   <= '0;
         tick_q    <= 16'd0;
         idx_q     <= 4'd0;
         trig_q    <= 1'b0;
         osc_q     <= 12'd0;
         strobe_q  <= 1'b0;
         playing_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         presc_q   <= presc_d;
         tick_q    <= tick_d;
         idx_q     <= idx_d;
         trig_q    <= trig_d;
         osc_q     <= osc_d;
         strobe_q  <= strobe_d;
         playing_q <= playing_d;
      end
   end

   assign trig        = trig_q;
   assign osc_count   = osc_q;
   assign step_idx    = idx_q;
   assign step_strobe = strobe_q;
   assign playing     = playing_q;

endmodule
`default_nettype wire

// File: tb/tb_note_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_note_seq
//  Purpose  : Directed and randomized bench for note_seq against a
//             cycle-elapsed reference model (honours NOTE_SEQ_MIN_GATE_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_note_seq;

   localparam int TD = 16;
   localparam int MG = 64;

   logic        clk = 1'b0;
   logic        rst, wr_en, play;
   logic [3:0]  wr_addr, last_step;
   logic [7:0]  wr_data;
   logic [15:0] step_len, gate_len;
   logic        trig, step_strobe, playing;
   logic [11:0] osc_count;
   logic [3:0]  step_idx;

   always #5 clk = ~clk;

   note_seq #(.TICK_DIV(TD), .MIN_GATE(MG)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .play(play), .last_step(last_step), .step_len(step_len), .gate_len(gate_len),
      .trig(trig), .osc_count(osc_count), .step_idx(step_idx),
      .step_strobe(step_strobe), .playing(playing)
   );

   int nvec = 0;
   int nfail = 0;
   int BASE [12] = '{611, 576, 544, 513, 484, 457, 431, 407, 384, 363, 342, 323};

   // Reference model: elapsed cycles within the step, not tick/prescaler pairs.
   logic [7:0]  m_pat [16];
   logic [7:0]  m_word;
   logic [11:0] m_osc;
   logic [3:0]  m_idx;
   logic        m_trig, m_strobe, m_play;
   int          m_el;

   function automatic int osc_model(input logic [7:0] w);
      int s = int'(w[3:0]);
      if (s > 11) s = 11;
      return BASE[s] >> w[6:4];
   endfunction

   function automatic int gate_model(input int g);
`ifdef NOTE_SEQ_MIN_GATE_EN
      return (g > MG) ? g : MG;
`else
      return g;
`endif
   endfunction

   task automatic m_start(input int n);
      m_idx    = 4'(n);
      m_word   = m_pat[n];
      m_el     = 0;
      m_strobe = 1'b1;
      m_play   = 1'b1;
      if (!m_word[7]) begin
         m_osc  = 12'(osc_model(m_word));
         m_trig = gate_model(int'(gate_len)) > 0;
      end else begin
         m_trig = 1'b0;
      end
   endtask

   task automatic model_edge();
      int len;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_pat[i] = 8'h80;
         m_word = 8'h80; m_osc = 12'd0; m_idx = 4'd0;
         m_trig = 1'b0; m_strobe = 1'b0; m_play = 1'b0; m_el = 0;
         return;
      end
      len = (step_len == 16'd0) ? 1 : int'(step_len);
      if (!m_play) begin
         m_strobe = 1'b0;
         if (play) m_start(0);
      end else if (!play) begin
         m_play = 1'b0; m_trig = 1'b0; m_idx = 4'd0; m_strobe = 1'b0;
      end else if ((m_el % TD == TD - 1) && (m_el / TD >= len - 1)) begin
         m_start((m_idx >= last_step) ? 0 : int'(m_idx) + 1);
      end else begin
         m_el     = m_el + 1;
         m_strobe = 1'b0;
         m_trig   = !m_word[7] && (m_el < gate_model(int'(gate_len)) * TD);
      end
      if (wr_en) m_pat[wr_addr] = wr_data;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      #1;
      chk("cycle", {13'd0, trig, osc_count, step_idx, step_strobe, playing},
                   {13'd0, m_trig, m_osc, m_idx, m_strobe, m_play});
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic wr(input int a, input int d);
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = 8'(d);
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; play = 1'b0; wr_en = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      int hi, lo, extra, g;
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; play = 1'b0;
      last_step = '0; step_len = 16'd1; gate_len = 16'd0;

      // Reset state, with play and a write asserted alongside rst
      play = 1'b1; wr_en = 1'b1; wr_data = 8'h05;
      cyc(); cyc();
      chk("rst_outs", {trig, osc_count, step_idx, step_strobe, playing}, 19'd0);
      do_reset();

      // Single A step, gate half the step
      wr(0, 8'h09);
      last_step = 4'd0; step_len = 16'd4; gate_len = 16'd2; play = 1'b1;
      cyc();
      chk("a_strobe", {step_strobe, step_idx, playing}, {1'b1, 4'd0, 1'b1});
      chk("a_osc", osc_count, 363);
      hi = 0; extra = 0;
      for (int i = 0; i < 4 * TD; i++) begin
         if (trig) hi++;
         if (i > 0 && step_strobe) extra++;
         cyc();
      end
      g = gate_model(2);
      chk("a_trig_hi", hi, ((g < 4) ? g : 4) * TD);
      chk("a_no_mid_strobe", extra, 0);
      chk("a_period_strobe", step_strobe, 1);

      // Three steps with a rest and wrap
      do_reset();
      wr(0, 8'h00); wr(1, 8'h21); wr(2, 8'h80);
      last_step = 4'd2; step_len = 16'd2; gate_len = 16'd1; play = 1'b1;
      cyc();
      for (int s = 0; s < 3; s++) begin
         chk("w_idx", step_idx, s);
         chk("w_osc", osc_count, (s == 0) ? 611 : 144);
         hi = 0;
         repeat (2 * TD) begin
            if (trig) hi++;
            cyc();
         end
         if (s == 2) chk("w_rest_trig", hi, 0);
      end
      chk("w_wrap", {step_strobe, step_idx}, {1'b1, 4'd0});

      // Legato across the boundary
      do_reset();
      wr(0, 8'h00); wr(1, 8'h04);
      last_step = 4'd1; step_len = 16'd3; gate_len = 16'd5; play = 1'b1;
      cyc();
      chk("l_osc0", osc_count, 611);
      lo = 0;
      repeat (3 * TD) begin
         if (!trig) lo++;
         cyc();
      end
      chk("l_osc1", osc_count, 484);
      repeat (TD) begin
         if (!trig) lo++;
         cyc();
      end
      chk("l_no_gap", lo, 0);

      // Stop mid-gate, then restart
      play = 1'b0;
      cyc();
      chk("s_stop", {trig, playing, step_idx, step_strobe, osc_count},
                    {1'b0, 1'b0, 4'd0, 1'b0, 12'd484});
      run(5);
      play = 1'b1;
      cyc();
      chk("s_restart", {step_strobe, step_idx, osc_count}, {1'b1, 4'd0, 12'd611});

      // Rewrite of the playing step takes effect on next visit
      do_reset();
      wr(0, 8'h00); wr(1, 8'h02);
      last_step = 4'd1; step_len = 16'd2; gate_len = 16'd1; play = 1'b1;
      cyc();
      run(2 * TD);
      chk("r_step1", {step_idx, osc_count}, {4'd1, 12'd544});
      run(TD - 1);
      wr(1, 8'h07);
      chk("r_unchanged", osc_count, 544);
      run(TD);
      chk("r_step0", {step_strobe, step_idx}, {1'b1, 4'd0});
      run(2 * TD);
      chk("r_new", {step_idx, osc_count}, {4'd1, 12'd407});

      // gate_len=0 with and without the minimum-gate floor
      do_reset();
      wr(0, 8'h00);
      last_step = 4'd0; step_len = 16'(2 * MG); gate_len = 16'd0; play = 1'b1;
      cyc();
      hi = 0;
      repeat (2 * MG * TD) begin
         if (trig) hi++;
         cyc();
      end
`ifdef NOTE_SEQ_MIN_GATE_EN
      chk("g0_trig_hi", hi, MG * TD);
`else
      chk("g0_trig_hi", hi, 0);
`endif

      // Randomized traffic, including mid-step control changes
      do_reset();
      step_len = 16'd2; gate_len = 16'd1; last_step = 4'd3; play = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         wr_en   = ($urandom_range(3) == 0);
         wr_addr = 4'($urandom);
         wr_data = 8'($urandom);
         if ($urandom_range(299) == 0) play = ~play;
         if ($urandom_range(149) == 0) last_step = 4'($urandom);
         if ($urandom_range(149) == 0) step_len = 16'($urandom_range(3));
         if ($urandom_range(99) == 0)  gate_len = 16'($urandom_range(4));
         rst = ($urandom_range(1999) == 0);
         cyc();
      end
      rst = 1'b0; wr_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/note_seq.md
NOTE_SEQ -- requirements
Module: note_seq

Interface
REQ-001 SHALL have parameter TICK_DIV, default 256, clk cycles per sequencer tick.
REQ-002 SHALL have parameter MIN_GATE, default 2048, minimum gate in ticks (two 78.125 Hz envelope periods) used under REQ-030.
REQ-003 SHALL have port: clk  input  1  system clock, 20.48 MHz.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: wr_en  input  1  pattern write strobe, one write per cycle.
REQ-006 SHALL have port: wr_addr  input  4  pattern step address.
REQ-007 SHALL have port: wr_data  input  8  step word: bit7 rest, bits6:4 octave, bits3:0 semitone.
REQ-008 SHALL have port: play  input  1  level; high runs the sequence.
REQ-009 SHALL have port: last_step  input  4  index of the final step before wrap to 0.
REQ-010 SHALL have port: step_len  input  16  step duration in ticks.
REQ-011 SHALL have port: gate_len  input  16  trig-high duration in ticks from step start.
REQ-012 SHALL have port: trig  output  1  note gate to the synth trig input.
REQ-013 SHALL have port: osc_count  output  12  oscillator period to the synth osc_count input.
REQ-014 SHALL have port: step_idx  output  4  currently playing step.
REQ-015 SHALL have port: step_strobe  output  1  one-cycle pulse at each step start.
REQ-016 SHALL have port: playing  output  1  high while in PLAY.

Function
REQ-017 SHALL hold a 16x8 pattern register array; a write with wr_en=1 updates entry wr_addr at the clock edge, in either state.
REQ-018 SHALL implement an FSM with states IDLE and PLAY; IDLE->PLAY when play=1, PLAY->IDLE when play=0.
REQ-019 SHALL start step 0 in the cycle after play is first sampled high: step_strobe=1, step_idx=0, playing=1, trig and osc_count valid in that same cycle.
REQ-020 SHALL count ticks with a prescaler cleared at each step start; one tick = TICK_DIV clk cycles; each step lasts exactly max(step_len,1)*TICK_DIV cycles.
REQ-021 SHALL advance step_idx by 1 at step end; step_idx==last_step wraps to 0; step_idx>last_step (last_step lowered mid-run) also wraps to 0.
REQ-022 SHALL latch the step word at step start; a write to the playing step takes effect at its next visit.
REQ-023 SHALL set osc_count = BASE[semi] >> octave, with BASE = 611,576,544,513,484,457,431,407,384,363,342,323 for semitones 0..11; semitone 12..15 SHALL use 11.
REQ-024 SHALL drive trig=1 from step start for gate_len ticks (gate_len*TICK_DIV cycles), then 0 until step end; gate_len=0 gives no trig.
REQ-025 SHALL keep trig=1 across the step boundary without a low cycle when effective gate >= step length and the next step is not a rest (legato).
REQ-026 SHALL, for a rest step (bit7=1), hold trig=0 for the whole step and keep the previous osc_count.
REQ-027 SHALL, on play=0 in PLAY, drive trig=0 and playing=0 in the next cycle, set step_idx=0, step_strobe=0; osc_count holds.
REQ-028 SHALL sample last_step, step_len and gate_len continuously; changes affect the current step's remaining comparisons from the next cycle.

Reset
REQ-029 SHALL on rst=1 set state IDLE, trig=0, osc_count=0, step_idx=0, step_strobe=0, playing=0, counters=0, all pattern entries=0x80 (rest); rst overrides wr_en and play in the same cycle.

Configuration
REQ-030 SHALL, with macro NOTE_SEQ_MIN_GATE_EN defined, use effective gate = max(gate_len, MIN_GATE) for non-rest steps; without it, effective gate = gate_len, gate_len=0 meaning no trig.

Verification
REQ-031 SHALL test: rst, write step0=0x09 (A, oct0), last_step=0, step_len=4, gate_len=2, play=1 -> osc_count=363, trig high 512 cycles, low 512, step_strobe every 1024 cycles.
REQ-032 SHALL test: steps 0..2 = 0x00, 0x21, 0x80, last_step=2 -> osc_count 611, 144, 144 held; trig absent in step 2; step_idx wraps 2->0.
REQ-033 SHALL test: step_len=3, gate_len=5, steps 0x00, 0x04 -> trig continuously high across the boundary; osc_count 611 then 484.
REQ-034 SHALL test: play=0 mid-gate -> trig=0, playing=0, step_idx=0 next cycle; play=1 again -> restarts at step 0 with strobe.
REQ-035 SHALL test: write step1 while step1 playing -> current step unchanged; new value appears on next visit.
REQ-036 SHALL test: gate_len=0 with NOTE_SEQ_MIN_GATE_EN defined, step_len=4096 -> trig high 2048*256 cycles; without the macro -> trig never high.
